// File: rtl/ct_spsram_init_wrap.sv
// Single-port SRAM wrapper with a 1-cycle registered read, a per-bit
// active-low write mask and a hardware initialisation sequencer. The
// sequencer writes INIT_VALUE to every entry, one entry per cycle, after
// reset (when INIT_ON_RESET = 1) or whenever init_req is seen in IDLE.
//
// Access semantics: an external access is accepted at a clock edge only
// when CEN = 0 and the sequencer is idle (init_busy = 0). While init_busy
// is high every external access is dropped silently, so callers gate
// their requests on init_busy. Read data appears on Q in the cycle after
// the accepting edge; Q holds its value at all other times.
module ct_spsram_init_wrap #(
  parameter int                    ADDR_WIDTH    = 8,
  parameter int                    DATA_WIDTH    = 23,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = {DATA_WIDTH{1'b0}},
  parameter bit                    INIT_ON_RESET = 1'b1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  init_req,
  output logic                  init_busy,
  output logic                  init_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_e;

  localparam state_e RST_STATE = INIT_ON_RESET ? ST_INIT : ST_IDLE;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   q_q, q_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    cnt_last;
  logic                    ext_en;
  logic                    rd_en;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   wr_mask;

  assign cnt_last = (cnt_q == CNT_LAST);

  // State register plus the control flops that share its reset.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      q_q     <= q_d;
    end
  end

  // Next state: a request in IDLE starts a sweep; the final write ends it.
  // Requests seen while sweeping, including on the final edge, are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (init_req) state_d = ST_INIT;
      ST_INIT: if (cnt_last) state_d = ST_IDLE;
      default: state_d = state_q;
    endcase
  end

  // Sequencer outputs: sweep counter and the one-cycle completion pulse.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: if (init_req) cnt_d = '0;
      ST_INIT: begin
        cnt_d  = cnt_q + CNT_ONE;
        done_d = cnt_last;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Array port selection: the sweep owns the port while busy, otherwise
  // an enabled external access drives it.
  always_comb begin
    ext_en  = (state_q == ST_IDLE) && !CEN;
    rd_en   = ext_en && GWEN;
    wr_en   = 1'b0;
    wr_addr = A;
    wr_data = D;
    wr_mask = ~WEN;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_data = INIT_VALUE;
      wr_mask = {DATA_WIDTH{1'b1}};
    end else if (ext_en && !GWEN) begin
      wr_en   = 1'b1;
    end
  end

  // Registered read data: updated only by an accepted read, held otherwise.
  always_comb begin
    q_d = q_q;
    if (rd_en) q_d = mem_q[A];
  end

  // Storage array: bitwise merge so unmasked bits keep their old value.
  always_ff @(posedge forever_cpuclk) begin
    if (wr_en) mem_q[wr_addr] <= (mem_q[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
  end

  assign Q         = q_q;
  assign init_busy = (state_q == ST_INIT);
  assign init_done = done_q;

endmodule

// File: tb/tb_ct_spsram_init_wrap.sv
// Bench for ct_spsram_init_wrap: default instance (256x23, sweep on reset)
// and a 64x64 instance with all-ones init value and no sweep on reset.
module tb_ct_spsram_init_wrap;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // default instance
  logic [7:0]  a1;
  logic        cen1, gwen1, req1, busy1, done1;
  logic [22:0] wen1, d1, q1;
  // variant instance
  logic [5:0]  a2;
  logic        cen2, gwen2, req2, busy2, done2;
  logic [63:0] wen2, d2, q2;

  ct_spsram_init_wrap dut1 (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .A(a1), .CEN(cen1), .GWEN(gwen1),
    .WEN(wen1), .D(d1), .Q(q1), .init_req(req1), .init_busy(busy1), .init_done(done1)
  );

  ct_spsram_init_wrap #(
    .ADDR_WIDTH(6), .DATA_WIDTH(64), .INIT_VALUE({64{1'b1}}), .INIT_ON_RESET(1'b0)
  ) dut2 (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .A(a2), .CEN(cen2), .GWEN(gwen2),
    .WEN(wen2), .D(d2), .Q(q2), .init_req(req2), .init_busy(busy2), .init_done(done2)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [22:0] model [256];
  logic rd_tag1 = 1'b0, rd_tag2 = 1'b0;
  logic launched1 = 1'b0, launched2 = 1'b0;

  always @(posedge clk) begin
    launched1 <= rd_tag1;
    launched2 <= rd_tag2;
  end

  always @(negedge clk) begin
    if (launched1 || launched2) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (launched1) chk("rd1", 64'(q1), e);
        else           chk("rd2", q2, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = '0;
  endtask

  task automatic wr1(input logic [7:0] a, input logic [22:0] d, input logic [22:0] wen);
    @(negedge clk);
    a1 = a; d1 = d; wen1 = wen; gwen1 = 1'b0; cen1 = 1'b0;
    model[a] = (model[a] & wen) | (d & ~wen);
    @(negedge clk);
    cen1 = 1'b1; gwen1 = 1'b1;
  endtask

  task automatic rd1(input logic [7:0] a);
    @(negedge clk);
    a1 = a; gwen1 = 1'b1; cen1 = 1'b0; rd_tag1 = 1'b1;
    exp_q.push_back(64'(model[a]));
    @(negedge clk);
    cen1 = 1'b1; rd_tag1 = 1'b0;
  endtask

  // write then read the same address on back-to-back edges
  task automatic wr_rd1(input logic [7:0] a, input logic [22:0] d, input logic [22:0] wen);
    @(negedge clk);
    a1 = a; d1 = d; wen1 = wen; gwen1 = 1'b0; cen1 = 1'b0;
    model[a] = (model[a] & wen) | (d & ~wen);
    @(negedge clk);
    gwen1 = 1'b1; rd_tag1 = 1'b1;
    exp_q.push_back(64'(model[a]));
    @(negedge clk);
    cen1 = 1'b1; rd_tag1 = 1'b0;
  endtask

  task automatic wr2(input logic [5:0] a, input logic [63:0] d, input logic [63:0] wen);
    @(negedge clk);
    a2 = a; d2 = d; wen2 = wen; gwen2 = 1'b0; cen2 = 1'b0;
    @(negedge clk);
    cen2 = 1'b1; gwen2 = 1'b1;
  endtask

  task automatic rd2(input logic [5:0] a, input logic [63:0] exp);
    @(negedge clk);
    a2 = a; gwen2 = 1'b1; cen2 = 1'b0; rd_tag2 = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    cen2 = 1'b1; rd_tag2 = 1'b0;
  endtask

  // Called at a negedge while a sweep is running. Counts sampled cycles
  // with busy high, optionally pokes dropped accesses into dut1 and
  // raises init_req at chosen samples, then checks the done pulse.
  task automatic sweep_watch(input bit sel, input int exp_n, input int poke_n,
                             input int req_a, input int req_b);
    int n;
    n = 0;
    while ((sel ? busy2 : busy1) && n < 2000) begin
      n++;
      if (n == poke_n) begin
        a1 = 8'h01; d1 = 23'h2AAAAA; wen1 = '0; gwen1 = 1'b0; cen1 = 1'b0;
      end else if (n == poke_n + 1) begin
        a1 = 8'h12; gwen1 = 1'b1; cen1 = 1'b0;
      end else begin
        cen1 = 1'b1; gwen1 = 1'b1;
      end
      if (sel) req2 = (n == req_a) || (n == req_b);
      else     req1 = (n == req_a) || (n == req_b);
      @(negedge clk);
    end
    req1 = 1'b0; req2 = 1'b0; cen1 = 1'b1; gwen1 = 1'b1;
    chk(sel ? "busy_len2" : "busy_len1", 64'(n), 64'(exp_n));
    chk(sel ? "done_pulse2" : "done_pulse1", 64'(sel ? done2 : done1), 64'd1);
    @(negedge clk);
    chk(sel ? "done_fall2" : "done_fall1", 64'(sel ? done2 : done1), 64'd0);
    chk(sel ? "busy_stay2" : "busy_stay1", 64'(sel ? busy2 : busy1), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]  ra [16];
    logic [22:0] rd_v, rw_v;

    rst_n = 1'b0;
    a1 = '0; cen1 = 1'b1; gwen1 = 1'b1; wen1 = '1; d1 = '0; req1 = 1'b0;
    a2 = '0; cen2 = 1'b1; gwen2 = 1'b1; wen2 = '1; d2 = '0; req2 = 1'b0;
    #22;
    chk("rst_q1", 64'(q1), 64'd0);
    chk("rst_done1", 64'(done1), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd1);
    chk("rst_q2", q2, 64'd0);
    chk("rst_busy2", 64'(busy2), 64'd0);

    // sweep from reset release
    @(negedge clk);
    rst_n = 1'b1;
    sweep_watch(1'b0, 256, -1, -1, -1);
    model_clear();
    rd1(8'h00); rd1(8'h7F); rd1(8'hFF);

    // byte-masked writes and an all-masked write
    wr1(8'h12, 23'h7FFFFF, 23'h7FFF00);
    rd1(8'h12);
    chk("mask_byte", 64'(model[8'h12]), 64'h0000FF);
    wr1(8'h12, 23'h000000, 23'h7FFFFE);
    rd1(8'h12);
    chk("mask_bit", 64'(model[8'h12]), 64'h0000FE);
    wr1(8'h12, 23'h000000, 23'h7FFFFF);
    rd1(8'h12);

    // random masked writes then readback
    for (int i = 0; i < 16; i++) begin
      ra[i] = 8'($urandom_range(32, 255));
      rd_v  = 23'($urandom_range(0, 32'h7FFFFF));
      rw_v  = 23'($urandom_range(0, 32'h7FFFFF));
      wr1(ra[i], rd_v, rw_v);
    end
    for (int i = 15; i >= 0; i--) rd1(ra[i]);

    // read-after-write, then Q hold under CEN = 1 and across a write
    wr_rd1(8'h05, 23'h1ABCDE, 23'h000000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("q_hold_idle", 64'(q1), 64'h1ABCDE);
    end
    wr1(8'h06, 23'h0F0F0F, 23'h000000);
    chk("q_hold_wr", 64'(q1), 64'h1ABCDE);

    // accesses during a requested sweep are dropped; repeated requests,
    // including one on the final edge, do not extend the sweep
    @(negedge clk);
    req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    a1 = 8'h10; d1 = 23'h123456; wen1 = '0; gwen1 = 1'b0; cen1 = 1'b0;
    chk("busy_req", 64'(busy1), 64'd1);
    @(negedge clk);
    cen1 = 1'b1; gwen1 = 1'b1;
    sweep_watch(1'b0, 255, 150, 60, 255);
    chk("q_hold_sweep", 64'(q1), 64'h1ABCDE);
    model_clear();
    rd1(8'h10); rd1(8'h01); rd1(8'h06);

    // asynchronous reset part way through a sweep
    wr_rd1(8'h05, 23'h1ABCDE, 23'h000000);
    @(negedge clk);
    req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_q", 64'(q1), 64'd0);
    chk("midrst_busy", 64'(busy1), 64'd1);
    chk("midrst_busy2", 64'(busy2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_watch(1'b0, 256, -1, 30, -1);
    model_clear();
    rd1(8'h05);

    // variant instance: no sweep on reset, all-ones init value
    chk("v_idle_busy", 64'(busy2), 64'd0);
    wr2(6'h3F, 64'd0, 64'd0);
    rd2(6'h3F, 64'd0);
    @(negedge clk);
    req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    sweep_watch(1'b1, 64, -1, -1, -1);
    rd2(6'h3F, 64'hFFFF_FFFF_FFFF_FFFF);
    rd2(6'h00, 64'hFFFF_FFFF_FFFF_FFFF);

    repeat (2) @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ct_spsram_init_wrap.md
Name: ct_spsram_init_wrap

Overview:
- Parametrised single-port SRAM wrapper: behavioural array, 1-cycle registered read, per-bit active-low write mask.
- Adds a hardware initialisation sequencer. After reset, or on request, it writes INIT_VALUE to every entry at one entry per cycle.
- Used by IFU/LSU predictor and tag arrays that must start from a known state without a software clearing loop.
- Also replaces the fixed-size 256x23 array wrappers.

Parameters:
ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH entries
DATA_WIDTH, 23, data width in bits
INIT_VALUE, {DATA_WIDTH{1'b0}}, value written to every entry during the sweep
INIT_ON_RESET, 1, 1 = start a sweep automatically on reset release; 0 = array stays uninitialised until init_req

Ports:
forever_cpuclk  input  1  clock
cpurst_b  input  1  asynchronous active-low reset
A  input  ADDR_WIDTH  access address
CEN  input  1  chip enable, active low
GWEN  input  1  global write enable, active low (0 = write, 1 = read)
WEN  input  DATA_WIDTH  per-bit write enable, active low
D  input  DATA_WIDTH  write data
Q  output  DATA_WIDTH  read data, registered
init_req  input  1  start a new initialisation sweep (level sampled each cycle)
init_busy  output  1  sweep in progress; external accesses ignored
init_done  output  1  one-cycle pulse on completion of a sweep

Behaviour:
- Clock and reset: one clock, forever_cpuclk. Reset is asynchronous and active-low on cpurst_b.
- Reset values:
  - Q = 0, init_done = 0, sweep counter = 0.
  - State = INIT if INIT_ON_RESET = 1, otherwise IDLE. init_busy equals (state == INIT) from reset.
  - Array contents are not reset.
- FSM states: IDLE, INIT.
  - IDLE -> INIT: init_req = 1 at a clock edge. Counter loads 0.
  - INIT: each edge writes INIT_VALUE to entry[counter] (all bits), then the counter increments.
  - INIT -> IDLE: at the edge that writes entry DEPTH-1. The sweep takes exactly DEPTH cycles.
  - init_done = 1 for the single cycle after that edge.
  - init_busy falls on the same edge that leaves INIT.
- init_req while in INIT: ignored; the sweep is not restarted.
- init_req in the same cycle as the final sweep write: ignored. The FSM returns to IDLE; the request must be reasserted.
- Reset mid-sweep: all state returns to reset values. If INIT_ON_RESET = 1, the sweep restarts from entry 0.
- External access (state IDLE, CEN = 0) at an edge:
  - Read (GWEN = 1): Q <= entry[A]. Data is visible in the cycle after the edge.
  - Write (GWEN = 0): for each bit i with WEN[i] = 0, entry[A][i] <= D[i]. Bits with WEN[i] = 1 keep their value. Q holds.
  - WEN all 1s with GWEN = 0: no array change. Q holds.
- CEN = 1: no array change; Q holds its previous value indefinitely.
- External access while init_busy = 1: dropped completely. No write, no Q update, Q holds.
  - Callers must gate requests on init_busy. No error is flagged.
- Read immediately after a write to the same address (consecutive edges): returns the newly written data. No bypass is needed.
- The address is used directly; all ADDR_WIDTH values are valid, so there is no out-of-range case.

Test Plan:
- Reset with INIT_ON_RESET = 1, default parameters:
  - init_busy = 1 for exactly 256 cycles after cpurst_b rises, then init_done pulses for 1 cycle.
  - Reads of A = 0x00, 0x7F and 0xFF then return Q = 0.
- Byte-masked write:
  - Write A = 0x12, D = 0x7FFFFF, WEN = 0x7FFF00 (write bits 7:0), then read A = 0x12 -> Q = 0x0000FF.
  - Write A = 0x12, D = 0x000000, WEN = 0x7FFFFE, then read -> Q = 0x0000FE.
- Q hold:
  - Read A = 0x05 (contents 0x1ABCDE) -> Q = 0x1ABCDE.
  - Ten cycles with CEN = 1, then a write to A = 0x06 -> Q stays 0x1ABCDE throughout.
- Access during sweep:
  - Assert init_req, then on the next cycle write A = 0x10, D = 0x123456.
  - init_busy = 1 and the write is dropped. After init_done, reading A = 0x10 -> Q = 0 (INIT_VALUE).
- Reset mid-sweep:
  - Assert cpurst_b = 0 asynchronously when the counter = 100 -> Q = 0 immediately.
  - After release, init_busy stays high for a full 256 cycles. init_req during the sweep does not extend it.
- Parameter variant ADDR_WIDTH = 6, DATA_WIDTH = 64, INIT_VALUE = all 1s, INIT_ON_RESET = 0:
  - After reset init_busy = 0.
  - A pulsed init_req -> busy for 64 cycles. Then a read of A = 0x3F -> Q = 0xFFFF_FFFF_FFFF_FFFF.
